// File: rtl/mult_div_seq.sv
// Multicycle multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// The operation runs on operand magnitudes, and the signs are applied in a final fix-up step.
module mult_div_seq #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1,
  parameter int CNT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  state_t             state_reg;
  logic               mode_reg;
  logic               sign_q_reg;
  logic               sign_r_reg;
  logic [WIDTH-1:0]   op_a_reg;
  logic [WIDTH-1:0]   op_b_reg;
  logic [WIDTH-1:0]   mag_a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               neg_a;
  logic               neg_b;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign neg_a = SIGNED && op_a_reg[WIDTH-1];
  assign neg_b = SIGNED && op_b_reg[WIDTH-1];

  // mag_a_reg shifts out MSB-first and serves as the multiplier and the dividend.
  // For a divide, acc holds {remainder, quotient}.
  always_comb begin
    trial      = {acc_reg[2*WIDTH-1:WIDTH], mag_a_reg[WIDTH-1]};
    trial_diff = trial - {1'b0, mag_b_reg};
    mul_next   = {acc_reg[2*WIDTH-2:0], 1'b0} +
                 {{WIDTH{1'b0}}, (mag_a_reg[WIDTH-1] ? mag_b_reg : {WIDTH{1'b0}})};
    if (trial >= {1'b0, mag_b_reg})
      div_next = {trial_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      div_next = {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    prod_fix = sign_q_reg ? -acc_reg : acc_reg;
    quo_fix  = sign_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = sign_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_reg  <= IDLE;
      mode_reg   <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_a_reg  <= op_a;
            op_b_reg  <= op_b;
            mode_reg  <= mode;
            busy      <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          mag_a_reg  <= neg_a ? -op_a_reg : op_a_reg;
          mag_b_reg  <= neg_b ? -op_b_reg : op_b_reg;
          sign_q_reg <= neg_a ^ neg_b;
          sign_r_reg <= neg_a;
          acc_reg    <= '0;
          cnt_reg    <= '0;
          if (mode_reg && (op_b_reg == '0)) begin
            done      <= 1'b1;
            div0      <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= mode_reg ? div_next : mul_next;
          mag_a_reg <= {mag_a_reg[WIDTH-2:0], 1'b0};
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH-1))
            state_reg <= FIX;
        end
        FIX: begin
          if (mode_reg) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done      <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done      <= 1'b0;
          div0      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: a 32-bit signed instance and an 8-bit unsigned instance.
// Stimulus comes from a vector table, a few directed handshake/reset sequences and random operations.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start32, mode32, busy32, done32, div0_32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, mode8, busy8, done8, div0_8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_hi [2];
  logic [31:0] prev_lo [2];

  mult_div_seq #(.WIDTH(32), .SIGNED(1'b1)) u_dut32 (
    .clk(clk), .reset_in(reset_in), .start(start32), .mode(mode32),
    .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .div0(div0_32),
    .hi(hi32), .lo(lo32)
  );

  mult_div_seq #(.WIDTH(8), .SIGNED(1'b0)) u_dut8 (
    .clk(clk), .reset_in(reset_in), .start(start8), .mode(mode8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .div0(div0_8),
    .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sel;   // 0 = 32-bit signed instance, 1 = 8-bit unsigned instance
    bit          mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          div0;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_hi(input bit sel);
    return sel ? {24'h0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] cur_lo(input bit sel);
    return sel ? {24'h0, lo8} : lo32;
  endfunction
  function automatic bit cur_done(input bit sel);
    return sel ? done8 : done32;
  endfunction
  function automatic bit cur_busy(input bit sel);
    return sel ? busy8 : busy32;
  endfunction
  function automatic bit cur_div0(input bit sel);
    return sel ? div0_8 : div0_32;
  endfunction

  // Reference model using plain integer arithmetic.
  function automatic void ref_op(input bit sel, input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] ehi, output logic [31:0] elo, output bit ed0);
    int     sa, sb, ua, ub;
    longint p;
    ed0 = 1'b0;
    ehi = prev_hi[sel];
    elo = prev_lo[sel];
    if (!sel) begin
      sa = a;
      sb = b;
      if (!m) begin
        p   = longint'(sa) * longint'(sb);
        ehi = p[63:32];
        elo = p[31:0];
      end else if (b == 32'h0) begin
        ed0 = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        elo = a;
        ehi = 32'h0;
      end else begin
        elo = sa / sb;
        ehi = sa % sb;
      end
    end else begin
      ua = int'(a[7:0]);
      ub = int'(b[7:0]);
      if (!m) begin
        ehi = (ua * ub) / 256;
        elo = (ua * ub) % 256;
      end else if (ub == 0) begin
        ed0 = 1'b1;
      end else begin
        elo = ua / ub;
        ehi = ua % ub;
      end
    end
  endfunction

  task automatic do_op(input bit sel, input bit m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit ed0, input string tag);
    int lat;
    bit busy_ok, hold_ok;
    @(negedge clk);
    if (sel) begin
      start8 = 1'b1; mode8 = m; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; mode32 = m; a32 = a; b32 = b;
    end
    @(negedge clk);
    // Operands scrambled after the sampling edge must not matter.
    if (sel) begin
      start8 = 1'b0; mode8 = ~m; a8 = 8'($urandom); b8 = 8'($urandom);
    end else begin
      start32 = 1'b0; mode32 = ~m; a32 = $urandom; b32 = $urandom;
    end
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!cur_done(sel) && lat < 100) begin
      if (!cur_busy(sel)) busy_ok = 1'b0;
      if (cur_hi(sel) !== prev_hi[sel] || cur_lo(sel) !== prev_lo[sel]) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), ed0 ? 64'd1 : (sel ? 64'd10 : 64'd34));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " hi"}, 64'(cur_hi(sel)), 64'(ehi));
    chk({tag, " lo"}, 64'(cur_lo(sel)), 64'(elo));
    chk({tag, " div0"}, 64'(cur_div0(sel)), 64'(ed0));
    $display("%s: w%0d mode=%0d a=%h b=%h -> hi=%h lo=%h div0=%0d lat=%0d",
             tag, sel ? 8 : 32, m, a, b, cur_hi(sel), cur_lo(sel), cur_div0(sel), lat);
    prev_hi[sel] = ehi;
    prev_lo[sel] = elo;
    @(negedge clk);
    chk({tag, " pulse end"}, {61'h0, cur_done(sel), cur_div0(sel), cur_busy(sel)}, 64'h0);
  endtask

  vec_t        tbl [15];
  logic [31:0] la [0:119];
  logic [31:0] lb [0:119];
  bit          lm [0:119];

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    bit          ed0, rm, rs, seen_done;
    int          r;

    tbl[0]  = '{0, 1, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0, 32'h0, 0};
    tbl[0].mode = 0; tbl[0].hi = 32'hFFFF_FFFF; tbl[0].lo = 32'hFFFF_FFEB;
    tbl[1]  = '{0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    tbl[2]  = '{0, 1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1};
    tbl[3]  = '{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0};
    tbl[4]  = '{0, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0};
    tbl[5]  = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0};
    tbl[6]  = '{0, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0};
    tbl[7]  = '{0, 1, 32'd100,       32'd7,         32'd2,         32'd14,        0};
    tbl[8]  = '{0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0};
    tbl[9]  = '{0, 0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 0};
    tbl[10] = '{1, 0, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0};
    tbl[11] = '{1, 1, 32'hFF, 32'h10, 32'h0F, 32'h0F, 0};
    tbl[12] = '{1, 1, 32'h0A, 32'h00, 32'h0F, 32'h0F, 1};
    tbl[13] = '{1, 0, 32'h80, 32'h02, 32'h01, 32'h00, 0};
    tbl[14] = '{1, 1, 32'h07, 32'hFF, 32'h07, 32'h00, 0};

    reset_in = 1'b1;
    start32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; mode8  = 1'b0; a8  = '0; b8  = '0;
    prev_hi[0] = '0; prev_lo[0] = '0; prev_hi[1] = '0; prev_lo[1] = '0;
    repeat (2) @(negedge clk);
    chk("reset ctl32", {61'h0, busy32, done32, div0_32}, 64'h0);
    chk("reset ctl8",  {61'h0, busy8, done8, div0_8}, 64'h0);
    chk("reset hilo32", {hi32, lo32}, 64'h0);
    chk("reset hilo8",  {48'h0, hi8, lo8}, 64'h0);
    reset_in = 1'b0;

    for (int i = 0; i < 15; i++)
      do_op(tbl[i].sel, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].div0,
            $sformatf("vec%0d", i));

    // Start held high with new operands every cycle: one operation per accepted edge.
    seen_done = 1'b0;
    for (int n = 0; n < 116; n++) begin
      @(negedge clk);
      if (n == 35 || n == 71 || n == 107) begin
        ref_op(0, lm[n-35], la[n-35], lb[n-35], ehi, elo, ed0);
        chk($sformatf("hs%0d done", n), 64'(done32), 64'd1);
        chk($sformatf("hs%0d hi", n), 64'(hi32), 64'(ehi));
        chk($sformatf("hs%0d lo", n), 64'(lo32), 64'(elo));
        $display("handshake: mode=%0d a=%h b=%h -> hi=%h lo=%h", lm[n-35], la[n-35], lb[n-35], hi32, lo32);
        prev_hi[0] = ehi; prev_lo[0] = elo;
      end else if (done32) begin
        seen_done = 1'b1;
      end
      if (n <= 107) begin
        lm[n] = 1'($urandom); la[n] = $urandom; lb[n] = $urandom | 32'h1;
        start32 = 1'b1; mode32 = lm[n]; a32 = la[n]; b32 = lb[n];
      end else begin
        start32 = 1'b0;
      end
    end
    chk("hs stray done", 64'(seen_done), 64'd0);

    // Asynchronous reset in the middle of RUN.
    do_op(0, 0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, "preload");
    @(negedge clk);
    start32 = 1'b1; mode32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
    @(negedge clk);
    start32 = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid busy", 64'(busy32), 64'd1);
    #2 reset_in = 1'b1;
    #1;
    chk("arst ctl32", {61'h0, busy32, done32, div0_32}, 64'h0);
    chk("arst hilo32", {hi32, lo32}, 64'h0);
    chk("arst hilo8", {48'h0, hi8, lo8}, 64'h0);
    $display("async reset: busy=%0d hi=%h lo=%h", busy32, hi32, lo32);
    prev_hi[0] = '0; prev_lo[0] = '0; prev_hi[1] = '0; prev_lo[1] = '0;
    @(negedge clk);
    reset_in = 1'b0;
    seen_done = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (done32 || busy32) seen_done = 1'b1;
    end
    chk("abort quiet", 64'(seen_done), 64'd0);
    do_op(0, 1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "after reset");

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom);
      rm = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      r  = int'($urandom_range(0, 7));
      if (r == 0) rb = 32'h0;
      else if (r == 1) begin
        rb = 32'hFFFF_FFFF;
        if (1'($urandom)) ra = 32'h8000_0000;
      end else if (r == 2) rb = 32'($urandom_range(1, 15));
      if (rs) begin
        ra = {24'h0, ra[7:0]};
        rb = {24'h0, rb[7:0]};
      end
      ref_op(rs, rm, ra, rb, ehi, elo, ed0);
      do_op(rs, rm, ra, rb, ehi, elo, ed0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
